// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding command-to-AXI4-Lite master: one command in, one AXI read or write, one response out.
// Optional macro ERR_COUNT_EN adds err_count, a saturating count of non-OKAY B/R responses.
module axi_lite_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 12,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
`ifdef ERR_COUNT_EN
  ,
  output logic [15:0]                     err_count
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                            state_reg, state_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_reg, addr_next;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_reg, wdata_next;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_reg, wstrb_next;
  logic                              write_reg, write_next;
  logic                              aw_done_reg, aw_done_next;
  logic                              w_done_reg, w_done_next;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_reg, rdata_next;
  logic [1:0]                        resp_reg, resp_next;
`ifdef ERR_COUNT_EN
  logic [15:0]                       err_count_reg, err_count_next;
`endif

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      write_reg     <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rdata_reg     <= '0;
      resp_reg      <= 2'b00;
`ifdef ERR_COUNT_EN
      err_count_reg <= 16'h0000;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      write_reg     <= write_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      rdata_reg     <= rdata_next;
      resp_reg      <= resp_next;
`ifdef ERR_COUNT_EN
      err_count_reg <= err_count_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    write_next   = write_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    rdata_next   = rdata_reg;
    resp_next    = resp_reg;
    unique case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_next    = cmd_addr;
          wdata_next   = cmd_wdata;
          wstrb_next   = cmd_wstrb;
          write_next   = cmd_write;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; advance once both have been seen.
        aw_done_next = aw_done_reg | M_AXI_AWREADY;
        w_done_next  = w_done_reg | M_AXI_WREADY;
        if (aw_done_next && w_done_next) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_next  = M_AXI_BRESP;
          rdata_next = '0;
          state_next = RSP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          resp_next  = M_AXI_RRESP;
          rdata_next = M_AXI_RDATA;
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ERR_COUNT_EN
  always_comb begin
    err_count_next = err_count_reg;
    if (((M_AXI_BVALID && M_AXI_BREADY && (M_AXI_BRESP != 2'b00)) ||
         (M_AXI_RVALID && M_AXI_RREADY && (M_AXI_RRESP != 2'b00))) &&
        (err_count_reg != 16'hFFFF))
      err_count_next = err_count_reg + 16'd1;
  end

  assign err_count = err_count_reg;
`endif

  // Handshake outputs decode straight from the state register so reset clears them immediately.
  assign cmd_ready     = (state_reg == IDLE) && !M_AXI_ARESET;
  assign M_AXI_AWVALID = (state_reg == WR_REQ) && !aw_done_reg;
  assign M_AXI_WVALID  = (state_reg == WR_REQ) && !w_done_reg;
  assign M_AXI_BREADY  = (state_reg == WR_RESP);
  assign M_AXI_ARVALID = (state_reg == RD_REQ);
  assign M_AXI_RREADY  = (state_reg == RD_DATA);
  assign rsp_valid     = (state_reg == RSP);

  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign rsp_write     = write_reg;
  assign rsp_rdata     = rdata_reg;
  assign rsp_resp      = resp_reg;

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 12, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have ports (clock and reset first), with one clock and an asynchronous, active-high reset:
- M_AXI_ACLK  in  1  sole clock; all logic rising-edge.
- M_AXI_ARESET  in  1  asynchronous, active-high reset.
- cmd_valid, cmd_ready  in, out  1 each  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid, rsp_ready  out, in  1 each  response handshake.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured from the slave.
- M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWREADY  out, out, in  ADDR_WIDTH, 1, 1.
- M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WREADY  out, out, out, in  32, 4, 1, 1.
- M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY  in, in, out  2, 1, 1.
- M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARREADY  out, out, in  ADDR_WIDTH, 1, 1.
- M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, M_AXI_RREADY  in, in, in, out  32, 2, 1, 1.
- err_count  out  16  present only with ERR_COUNT_EN (see REQ-022).

Function
REQ-004 SHALL implement a registered FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-005 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-006 SHALL, on acceptance, register addr, wdata, wstrb and write, then move to WR_REQ (write) or RD_REQ (read).
REQ-007 SHALL assert AWVALID and WVALID together on the first WR_REQ cycle, one cycle after acceptance.
REQ-008 SHALL hold AWVALID until AWREADY is sampled high, and WVALID until WREADY is sampled high, each dropping independently.
REQ-009 SHALL keep AWADDR, WDATA and WSTRB stable while the corresponding VALID is high.
REQ-010 SHALL go from WR_REQ to WR_RESP when both AW and W handshakes are done; handshakes may complete in the same or different cycles.
REQ-011 SHALL assert BREADY only in WR_RESP; on BVALID, SHALL capture BRESP into rsp_resp, clear rsp_rdata and move to RSP.
REQ-012 SHALL assert ARVALID in RD_REQ until ARREADY, then move to RD_DATA.
REQ-013 SHALL assert RREADY only in RD_DATA; on RVALID, SHALL capture RDATA into rsp_rdata and RRESP into rsp_resp, then move to RSP.
REQ-014 SHALL assert rsp_valid only in RSP, holding rsp_* stable until rsp_ready; on that handshake SHALL return to IDLE.
REQ-015 SHALL take exactly one outstanding transaction; with zero-wait slave and rsp_ready = 1, the write turnaround is accept -> WR_REQ -> WR_RESP -> RSP -> IDLE (4 cycles min); reads are the same.
REQ-016 SHALL not accept a new command in the cycle rsp handshakes; cmd_ready rises the following cycle.
REQ-017 SHALL never drop any VALID before its READY, regardless of cmd_* or rsp_ready activity.
REQ-018 SHALL ignore BVALID/RVALID arriving outside WR_RESP/RD_DATA; no state change.

Reset
REQ-019 SHALL, on M_AXI_ARESET = 1 asynchronously, force state = IDLE and cmd_ready = 0 while reset is held.
REQ-020 SHALL, on reset, force rsp_valid, AWVALID, WVALID, ARVALID, BREADY, RREADY = 0 and rsp_rdata, rsp_resp, rsp_write, address/data registers = 0 (err_count = 0 if present).
REQ-021 SHALL, on reset mid-transaction, abandon the transaction and produce no response; cmd_ready = 1 on the first clock after release.

Configuration
REQ-022 SHALL, when macro ERR_COUNT_EN is defined, provide err_count: a 16-bit counter incremented on each B or R handshake with resp != 2'b00, saturating at 16'hFFFF.
REQ-023 SHALL, without ERR_COUNT_EN, omit the err_count port and counter; all other behaviour is identical.

Verification
REQ-024 Write 0x800 / 0xDEADBEEF / wstrb F with a zero-wait slave -> AW and W in the same cycle, BREADY 1 cycle later, rsp_valid with resp 00 and rdata 0.
REQ-025 AWREADY 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID held with WDATA stable, BREADY only after both handshakes.
REQ-026 Read 0x804 with slave RDATA 0x12345678 after 2 wait cycles -> rsp_rdata 0x12345678, rsp_write 0, resp 00.
REQ-027 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready 0 throughout, new command accepted the cycle after rsp_ready.
REQ-028 Reset asserted while WVALID = 1 -> all VALID/READY outputs 0 immediately (async), no rsp_valid, cmd_ready 1 after release.
REQ-029 With ERR_COUNT_EN: three reads returning RRESP 10 -> err_count = 3; a write returning BRESP 00 -> err_count unchanged.
